pi_request_queue: RTL and testbench

Buffers bus requests that the Pi writes through the GPIO register port, and issues them one at a time to the 68k bus-cycle engine over a valid/ready handshake. Posted writes queue up so the Pi does not stall on each one. Long (32-bit) requests are split into two word cycles, high word first, and the read data is returned as one 32-bit result. The block sits between the Pi register decoder (the `pi_wr_falling` strobe) and the bus state machine that drives AS/UDS/LDS.

---
 rtl/pistorm_bus_pkg.sv | 36 +++
 rtl/sync_fifo.sv | 49 ++++
 rtl/pi_request_queue.sv | 215 +++++++++++++++++++++
 tb/tb_pi_request_queue.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pistorm_bus_pkg.sv
// Shared definitions for the Pi-to-68k request path: register map, size codes,
// ADDR_HI field layout, queue entry format and issue FSM states.
package pistorm_bus_pkg;

  localparam logic [2:0] RegDataLo = 3'd0;
  localparam logic [2:0] RegDataHi = 3'd1;
  localparam logic [2:0] RegAddrLo = 3'd2;
  localparam logic [2:0] RegAddrHi = 3'd3;

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeWord = 2'd1;
  localparam logic [1:0] SizeLong = 2'd2;
  localparam logic [1:0] SizeBad  = 2'd3;

  localparam int unsigned AhAddrLsb = 0;
  localparam int unsigned AhSizeLsb = 8;
  localparam int unsigned AhReadBit = 10;
  localparam int unsigned AhFcLsb   = 11;

  typedef struct packed {
    logic [23:0] addr;
    logic [2:0]  fc;
    logic        read;
    logic [1:0]  size;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue1,
    StWait1,
    StIssue2,
    StWait2
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count; a push while full is taken only alongside a pop.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pi_request_queue.sv
// Queues Pi register-port bus requests and issues them in order to the 68k bus engine,
// splitting long accesses into two word cycles (high word first).
module pi_request_queue
  import pistorm_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        wr_strobe,
  input  logic [2:0]  wr_reg,
  input  logic [15:0] wr_data,
  output logic        cyc_valid,
  input  logic        cyc_ready,
  output logic [23:0] cyc_addr,
  output logic [2:0]  cyc_fc,
  output logic        cyc_read,
  output logic [1:0]  cyc_size,
  output logic [15:0] cyc_wdata,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_data,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        busy,
  output logic        overflow,
  output logic        bad_size
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [15:0] addr_lo_q, addr_lo_d;
  logic        cyc_valid_q, cyc_valid_d;
  logic [23:0] cyc_addr_q, cyc_addr_d;
  logic [2:0]  cyc_fc_q, cyc_fc_d;
  logic        cyc_read_q, cyc_read_d;
  logic [1:0]  cyc_size_q, cyc_size_d;
  logic [15:0] cyc_wdata_q, cyc_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        overflow_q, overflow_d;
  logic        bad_size_q, bad_size_d;

  entry_t          head, new_entry;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic            commit, head_long;
  logic            unused_wr_data;

  assign unused_wr_data = ^wr_data[15:14];

  assign commit    = wr_strobe && (wr_reg == RegAddrHi);
  assign head_long = (head.size == SizeLong);

  assign new_entry.addr = {wr_data[AhAddrLsb +: 8], addr_lo_q};
  assign new_entry.fc   = wr_data[AhFcLsb +: 3];
  assign new_entry.read = wr_data[AhReadBit];
  assign new_entry.size = wr_data[AhSizeLsb +: 2];
  assign new_entry.data = data_q;

  sync_fifo #(
    .Width ($bits(entry_t)),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (new_entry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    addr_lo_d     = addr_lo_q;
    cyc_valid_d   = cyc_valid_q;
    cyc_addr_d    = cyc_addr_q;
    cyc_fc_d      = cyc_fc_q;
    cyc_read_d    = cyc_read_q;
    cyc_size_d    = cyc_size_q;
    cyc_wdata_d   = cyc_wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = rdata_valid_q;
    overflow_d    = overflow_q;
    bad_size_d    = bad_size_q;
    fifo_push     = 1'b0;
    fifo_pop      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d     = StIssue1;
          cyc_valid_d = 1'b1;
          cyc_addr_d  = head.addr;
          cyc_fc_d    = head.fc;
          cyc_read_d  = head.read;
          cyc_size_d  = head_long ? SizeWord : head.size;
          cyc_wdata_d = head_long ? head.data[31:16] : head.data[15:0];
        end
      end
      StIssue1: begin
        if (cyc_ready) begin
          cyc_valid_d = 1'b0;
          state_d     = StWait1;
        end
      end
      StWait1: begin
        if (rsp_valid) begin
          if (head_long) begin
            if (head.read) rdata_d[31:16] = rsp_data;
            state_d     = StIssue2;
            cyc_valid_d = 1'b1;
            cyc_addr_d  = head.addr + 24'd2;
            cyc_wdata_d = head.data[15:0];
          end else begin
            if (head.read) begin
              rdata_d       = {16'h0, rsp_data};
              rdata_valid_d = 1'b1;
            end
            fifo_pop = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      StIssue2: begin
        if (cyc_ready) begin
          cyc_valid_d = 1'b0;
          state_d     = StWait2;
        end
      end
      StWait2: begin
        if (rsp_valid) begin
          if (head.read) begin
            rdata_d[15:0] = rsp_data;
            rdata_valid_d = 1'b1;
          end
          fifo_pop = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A newly committed read supersedes any result landing in the same cycle.
    if (commit) begin
      if (new_entry.size == SizeBad) begin
        bad_size_d = 1'b1;
      end else if (!fifo_full || fifo_pop) begin
        fifo_push = 1'b1;
        if (new_entry.read) rdata_valid_d = 1'b0;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (wr_strobe) begin
      case (wr_reg)
        RegDataLo: data_d[15:0]  = wr_data;
        RegDataHi: data_d[31:16] = wr_data;
        RegAddrLo: addr_lo_d     = wr_data;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= StIdle;
      data_q        <= '0;
      addr_lo_q     <= '0;
      cyc_valid_q   <= 1'b0;
      cyc_addr_q    <= '0;
      cyc_fc_q      <= '0;
      cyc_read_q    <= 1'b0;
      cyc_size_q    <= '0;
      cyc_wdata_q   <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      bad_size_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      addr_lo_q     <= addr_lo_d;
      cyc_valid_q   <= cyc_valid_d;
      cyc_addr_q    <= cyc_addr_d;
      cyc_fc_q      <= cyc_fc_d;
      cyc_read_q    <= cyc_read_d;
      cyc_size_q    <= cyc_size_d;
      cyc_wdata_q   <= cyc_wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      overflow_q    <= overflow_d;
      bad_size_q    <= bad_size_d;
    end
  end

  assign cyc_valid   = cyc_valid_q;
  assign cyc_addr    = cyc_addr_q;
  assign cyc_fc      = cyc_fc_q;
  assign cyc_read    = cyc_read_q;
  assign cyc_size    = cyc_size_q;
  assign cyc_wdata   = cyc_wdata_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign overflow    = overflow_q;
  assign bad_size    = bad_size_q;
  assign busy        = (fifo_count != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_pi_request_queue.sv
// Directed bench for pi_request_queue: a transaction-level queue model checked every
// cycle, plus hand-computed expectations for timing and the named scenarios.
module tb_pi_request_queue;

  localparam int DEPTH = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        wr_strobe = 1'b0;
  logic [2:0]  wr_reg = '0;
  logic [15:0] wr_data = '0;
  logic        cyc_valid;
  logic        cyc_ready = 1'b0;
  logic [23:0] cyc_addr;
  logic [2:0]  cyc_fc;
  logic        cyc_read;
  logic [1:0]  cyc_size;
  logic [15:0] cyc_wdata;
  logic        rsp_valid = 1'b0;
  logic [15:0] rsp_data = '0;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        busy;
  logic        overflow;
  logic        bad_size;

  int total = 0;
  int bad = 0;
  int issued = 0;

  pi_request_queue #(.DEPTH(DEPTH)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .wr_strobe   (wr_strobe),
    .wr_reg      (wr_reg),
    .wr_data     (wr_data),
    .cyc_valid   (cyc_valid),
    .cyc_ready   (cyc_ready),
    .cyc_addr    (cyc_addr),
    .cyc_fc      (cyc_fc),
    .cyc_read    (cyc_read),
    .cyc_size    (cyc_size),
    .cyc_wdata   (cyc_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .busy        (busy),
    .overflow    (overflow),
    .bad_size    (bad_size)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic [23:0] addr;
    logic [2:0]  fc;
    logic        rd;
    logic [1:0]  size;
    logic [15:0] wdata;
  } cyc_t;

  typedef struct {
    logic rd;
    logic lng;
  } ent_t;

  cyc_t        exp_q[$];
  ent_t        ents[$];
  logic [31:0] m_data;
  logic [15:0] m_alo;
  logic [31:0] m_rdata;
  logic        m_rdv, m_ovf, m_bad, m_half, m_await, m_live;

  initial m_live = 1'b0;

  // Samples mid-cycle: check outputs against the model, then advance it by one edge.
  always @(negedge sys_clk) begin
    cyc_t        c;
    ent_t        e;
    logic        popped;
    logic [23:0] a;
    if (m_live) begin
      chk("busy", 32'(busy), 32'(ents.size() != 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("bad_size", 32'(bad_size), 32'(m_bad));
      chk("rdata_valid", 32'(rdata_valid), 32'(m_rdv));
      chk("rdata", rdata, m_rdata);
    end
    if (sys_rst) begin
      exp_q.delete();
      ents.delete();
      m_data = '0; m_alo = '0; m_rdata = '0;
      m_rdv = 0; m_ovf = 0; m_bad = 0; m_half = 0; m_await = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      popped = 1'b0;
      if (cyc_valid) begin
        if (m_await || exp_q.size() == 0) begin
          chk("cyc_valid unexpected", 32'(cyc_valid), 32'd0);
        end else begin
          c = exp_q[0];
          chk("cyc_addr", 32'(cyc_addr), 32'(c.addr));
          chk("cyc_fc", 32'(cyc_fc), 32'(c.fc));
          chk("cyc_read", 32'(cyc_read), 32'(c.rd));
          chk("cyc_size", 32'(cyc_size), 32'(c.size));
          chk("cyc_wdata", 32'(cyc_wdata), 32'(c.wdata));
          if (cyc_ready) begin
            void'(exp_q.pop_front());
            m_await = 1'b1;
            issued++;
          end
        end
      end else if (rsp_valid && m_await && ents.size() != 0) begin
        m_await = 1'b0;
        e = ents[0];
        if (e.lng && !m_half) begin
          if (e.rd) m_rdata[31:16] = rsp_data;
          m_half = 1'b1;
        end else begin
          if (e.rd) begin
            m_rdata = e.lng ? {m_rdata[31:16], rsp_data} : {16'h0, rsp_data};
            m_rdv = 1'b1;
          end
          void'(ents.pop_front());
          m_half = 1'b0;
          popped = 1'b1;
        end
      end
      if (wr_strobe) begin
        case (wr_reg)
          3'd0: m_data[15:0] = wr_data;
          3'd1: m_data[31:16] = wr_data;
          3'd2: m_alo = wr_data;
          3'd3: begin
            a = {wr_data[7:0], m_alo};
            c.fc = wr_data[13:11];
            c.rd = wr_data[10];
            if (wr_data[9:8] == 2'd3) begin
              m_bad = 1'b1;
            end else if (ents.size() < DEPTH || popped) begin
              e.rd = wr_data[10];
              e.lng = (wr_data[9:8] == 2'd2);
              ents.push_back(e);
              if (e.lng) begin
                c.addr = a; c.size = 2'd1; c.wdata = m_data[31:16];
                exp_q.push_back(c);
                c.addr = a + 24'd2; c.wdata = m_data[15:0];
                exp_q.push_back(c);
              end else begin
                c.addr = a; c.size = wr_data[9:8]; c.wdata = m_data[15:0];
                exp_q.push_back(c);
              end
              if (e.rd) m_rdv = 1'b0;
            end else begin
              m_ovf = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] r, input logic [15:0] d);
    wr_strobe = 1'b1; wr_reg = r; wr_data = d;
    tick();
    wr_strobe = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!cyc_valid && n < 20) begin
      tick();
      n++;
    end
    if (!cyc_valid) chk("cyc_valid timeout", 32'(cyc_valid), 32'd1);
  endtask

  // Accept the offered cycle, wait one cycle, then terminate it with data d.
  task automatic bus_cycle(input logic [15:0] d);
    cyc_ready = 1'b1;
    wait_valid();
    tick();
    cyc_ready = 1'b0;
    tick();
    rsp_valid = 1'b1; rsp_data = d;
    tick();
    rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    chk("rst cyc_valid", 32'(cyc_valid), 32'd0);
    chk("rst cyc_addr", 32'(cyc_addr), 32'd0);
    chk("rst cyc_size", 32'(cyc_size), 32'd0);
    chk("rst cyc_wdata", 32'(cyc_wdata), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst rdata_valid", 32'(rdata_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    chk("rst bad_size", 32'(bad_size), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    do_reset();

    // Word write: commit at N, busy at N+1, cyc_valid at N+2.
    wr(3'd0, 16'hBEEF);
    wr(3'd2, 16'h1234);
    wr(3'd3, 16'h0112);
    chk("t1 busy N+1", 32'(busy), 32'd1);
    chk("t1 cyc_valid N+1", 32'(cyc_valid), 32'd0);
    tick();
    chk("t1 cyc_valid N+2", 32'(cyc_valid), 32'd1);
    chk("t1 addr", 32'(cyc_addr), 32'h121234);
    chk("t1 size", 32'(cyc_size), 32'd1);
    chk("t1 read", 32'(cyc_read), 32'd0);
    chk("t1 wdata", 32'(cyc_wdata), 32'hBEEF);
    n0 = issued;
    bus_cycle(16'h0000);
    chk("t1 busy after rsp", 32'(busy), 32'd0);
    tick();
    chk("t1 one cycle", 32'(issued - n0), 32'd1);

    // Long read, high word first.
    wr(3'd2, 16'h0000);
    wr(3'd3, 16'h06F8);
    wait_valid();
    chk("t2 addr hi", 32'(cyc_addr), 32'hF80000);
    chk("t2 read", 32'(cyc_read), 32'd1);
    bus_cycle(16'h1111);
    chk("t2 addr lo", 32'(cyc_addr), 32'hF80002);
    bus_cycle(16'h2222);
    chk("t2 rdata", rdata, 32'h11112222);
    chk("t2 rdata_valid", 32'(rdata_valid), 32'd1);

    // Reset during WAIT1 of a long read, then a byte read.
    wr(3'd2, 16'h0000);
    wr(3'd3, 16'h06F8);
    chk("t6 read commit clears valid", 32'(rdata_valid), 32'd0);
    cyc_ready = 1'b1;
    wait_valid();
    tick();
    cyc_ready = 1'b0;
    tick();
    do_reset();
    tick();
    chk("t6 idle after reset", 32'(cyc_valid), 32'd0);
    wr(3'd2, 16'hE001);
    wr(3'd3, 16'h04BF);
    tick();
    chk("t6 byte valid", 32'(cyc_valid), 32'd1);
    chk("t6 byte addr", 32'(cyc_addr), 32'hBFE001);
    chk("t6 byte size", 32'(cyc_size), 32'd0);
    bus_cycle(16'h00A5);
    chk("t6 rdata", rdata, 32'h000000A5);
    chk("t6 rdata_valid", 32'(rdata_valid), 32'd1);

    // Bad size is dropped; a stray response while idle is ignored.
    wr(3'd3, 16'h0300);
    chk("t5 bad_size", 32'(bad_size), 32'd1);
    chk("t5 busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5 no cycle", 32'(cyc_valid), 32'd0);
    end
    rsp_valid = 1'b1; rsp_data = 16'h7777;
    tick();
    rsp_valid = 1'b0;
    tick();
    chk("t5 stray rsp rdata", rdata, 32'h000000A5);

    // Overflow: five commits into a four-deep queue with ready held low.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr(3'd0, 16'hA000 + 16'(i));
      wr(3'd2, 16'(i * 256));
      if (i == 3) chk("t3 no overflow at 4", 32'(overflow), 32'd0);
      wr(3'd3, 16'h2920);
    end
    chk("t3 overflow", 32'(overflow), 32'd1);
    chk("t3 head addr", 32'(cyc_addr), 32'h200000);
    chk("t3 head fc", 32'(cyc_fc), 32'd5);
    chk("t3 head wdata", 32'(cyc_wdata), 32'hA000);
    n0 = issued;
    for (int i = 0; i < 4; i++) bus_cycle(16'h0000);
    for (int i = 0; i < 4; i++) tick();
    chk("t3 four cycles", 32'(issued - n0), 32'd4);
    chk("t3 busy", 32'(busy), 32'd0);

    // Commit in the same cycle as the final response of a full queue.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr(3'd0, 16'hC000 + 16'(i));
      wr(3'd2, 16'(i * 16));
      wr(3'd3, 16'h0130);
    end
    wr(3'd0, 16'h5555);
    wr(3'd2, 16'h5000);
    n0 = issued;
    cyc_ready = 1'b1;
    wait_valid();
    tick();
    cyc_ready = 1'b0;
    tick();
    rsp_valid = 1'b1; rsp_data = 16'h0000;
    wr_strobe = 1'b1; wr_reg = 3'd3; wr_data = 16'h0155;
    tick();
    rsp_valid = 1'b0; wr_strobe = 1'b0;
    chk("t4 overflow", 32'(overflow), 32'd0);
    chk("t4 busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) bus_cycle(16'h0000);
    tick();
    chk("t4 last addr", 32'(cyc_addr), 32'h555000);
    chk("t4 last wdata", 32'(cyc_wdata), 32'h5555);
    bus_cycle(16'h0000);
    for (int i = 0; i < 4; i++) tick();
    chk("t4 five cycles", 32'(issued - n0), 32'd5);
    chk("t4 busy end", 32'(busy), 32'd0);
    chk("t4 overflow end", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
